execute_stage: RTL and testbench



---
 rtl/y86_pkg.sv | 59 +++++
 rtl/execute_stage_if.sv | 67 ++++++
 rtl/alu.sv | 40 ++++
 rtl/execute_stage_cond_eval.sv | 35 +++
 rtl/execute_stage.sv | 164 ++++++++++++++++
 tb/tb_execute_stage.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings for the execute stage: icodes, ALU
//               function codes, condition ifuns, stat codes, register "none"
//               and the condition-flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // ALU control codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Condition function codes for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Pipeline status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Register ID meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Condition-code flag bundle
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ============================================================================
// Module      : execute_stage_if
// Description : E-register inputs, stage control, forwarding outputs and
//               M-register outputs of the execute stage. Optional perf
//               counter signals appear when EXEC_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_stage_if #(
  parameter int W      = 64,
  parameter int PERF_W = 32
);
  logic [2:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valC;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic         m_exc;
  logic         W_exc;
  logic         M_stall;
  logic         M_bubble;

  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_cnd;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
`ifdef EXEC_PERF_EN
  logic [PERF_W-1:0] perf_ops;
  logic [PERF_W-1:0] perf_bubbles;
`endif

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           m_exc, W_exc, M_stall, M_bubble,
    input  e_valE, e_dstE, e_cnd, M_stat, M_icode, M_cnd, M_valE, M_valA,
           M_dstE, M_dstM, cc_zf, cc_sf, cc_of
`ifdef EXEC_PERF_EN
    , input perf_ops, perf_bubbles
`endif
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           m_exc, W_exc, M_stall, M_bubble,
    output e_valE, e_dstE, e_cnd, M_stat, M_icode, M_cnd, M_valE, M_valA,
           M_dstE, M_dstM, cc_zf, cc_sf, cc_of
`ifdef EXEC_PERF_EN
    , output perf_ops, perf_bubbles
`endif
  );

endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Team 64-bit ALU. control 00 add, 01 sub (num1-num2),
//               10 and, 11 xor. Signed overflow reported for add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
  parameter int W = 64
) (
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  input  logic [1:0]   control,
  output logic [W-1:0] result,
  output logic         overflow
);
  import y86_pkg::*;

  // Arithmetic/logic result and signed overflow
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = num1 + num2;
        overflow = (num1[W-1] == num2[W-1]) && (result[W-1] != num1[W-1]);
      end
      ALU_SUB: begin
        result   = num1 - num2;
        overflow = (num1[W-1] != num2[W-1]) && (result[W-1] != num1[W-1]);
      end
      ALU_AND: result = num1 & num2;
      default: result = num1 ^ num2;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage_cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Evaluates a jXX/cmovXX condition from the CC flags.
//               Unknown ifun values evaluate false.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval (
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cnd
);
  import y86_pkg::*;

  // Decode condition from flags
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Y86-64 execute stage. Selects ALU operands and function,
//               holds the ZF/SF/OF condition codes, evaluates jXX/cmovXX
//               conditions and registers results into the E->M register.
//               Optional perf counters enabled by macro EXEC_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage #(
  parameter int W      = 64,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);
  import y86_pkg::*;

  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [1:0]   w_alu_fun;
  logic [W-1:0] w_val_e;
  logic         w_alu_ovf_unused;
  flags_t       w_flags;
  logic         w_set_cc;
  logic         w_cond;
  logic         w_cnd;
  logic [3:0]   w_dst_e;
  flags_t       r_cc;

  logic [2:0]   r_m_stat;
  logic [3:0]   r_m_icode;
  logic         r_m_cnd;
  logic [W-1:0] r_m_val_e;
  logic [W-1:0] r_m_val_a;
  logic [3:0]   r_m_dst_e;
  logic [3:0]   r_m_dst_m;

  // Operand and function selection by instruction class
  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (bus.E_icode)
      RRMOVQ, OPQ:            w_alu_a = bus.E_valA;
      IRMOVQ, RMMOVQ, MRMOVQ: w_alu_a = bus.E_valC;
      CALL, PUSHQ:            w_alu_a = -W'(8);
      RET, POPQ:              w_alu_a = W'(8);
      default:                w_alu_a = '0;
    endcase
    case (bus.E_icode)
      RMMOVQ, MRMOVQ, OPQ, CALL, RET, PUSHQ, POPQ: w_alu_b = bus.E_valB;
      default:                                     w_alu_b = '0;
    endcase
    w_alu_fun = (bus.E_icode == OPQ) ? bus.E_ifun[1:0] : ALU_ADD;
  end

  // num1 = aluB, num2 = aluA so subtraction yields valB - valA
  alu #(.W(W)) u_alu (
    .num1     (w_alu_b),
    .num2     (w_alu_a),
    .control  (w_alu_fun),
    .result   (w_val_e),
    .overflow (w_alu_ovf_unused)
  );

  // Flags derived locally; the ALU's own overflow output is not trusted here
  always_comb begin
    w_flags.zf = (w_val_e == '0);
    w_flags.sf = w_val_e[W-1];
    case (w_alu_fun)
      ALU_ADD: w_flags.of = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_val_e[W-1] != w_alu_b[W-1]);
      ALU_SUB: w_flags.of = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_val_e[W-1] != w_alu_b[W-1]);
      default: w_flags.of = 1'b0;
    endcase
  end

  // CC only updates for a clean OPQ that will actually advance into M
  assign w_set_cc = (bus.E_icode == OPQ) && !bus.m_exc && !bus.W_exc &&
                    !bus.M_stall && !bus.M_bubble && (bus.E_stat == STAT_AOK);

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= flags_t'(3'b100);
    end else if (w_set_cc) begin
      r_cc <= w_flags;
    end
  end

  // Condition uses the CC value held before this cycle's update
  cond_eval u_cond_eval (
    .zf   (r_cc.zf),
    .sf   (r_cc.sf),
    .of   (r_cc.of),
    .ifun (bus.E_ifun),
    .cnd  (w_cond)
  );

  assign w_cnd   = ((bus.E_icode == JXX) || (bus.E_icode == RRMOVQ)) ? w_cond : 1'b1;
  assign w_dst_e = ((bus.E_icode == RRMOVQ) && !w_cnd) ? RNONE : bus.E_dstE;

  // E->M pipeline register: reset > stall (hold) > bubble (NOP) > load
  always_ff @(posedge clk) begin
    if (rst || (!bus.M_stall && bus.M_bubble)) begin
      r_m_stat  <= STAT_AOK;
      r_m_icode <= NOP;
      r_m_cnd   <= 1'b0;
      r_m_val_e <= '0;
      r_m_val_a <= '0;
      r_m_dst_e <= RNONE;
      r_m_dst_m <= RNONE;
    end else if (!bus.M_stall) begin
      r_m_stat  <= bus.E_stat;
      r_m_icode <= bus.E_icode;
      r_m_cnd   <= w_cnd;
      r_m_val_e <= w_val_e;
      r_m_val_a <= bus.E_valA;
      r_m_dst_e <= w_dst_e;
      r_m_dst_m <= bus.E_dstM;
    end
  end

`ifdef EXEC_PERF_EN
  logic [PERF_W-1:0] r_perf_ops;
  logic [PERF_W-1:0] r_perf_bubbles;

  // Count advancing non-NOP instructions and bubbles loaded into M
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops     <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (!bus.M_stall && !bus.M_bubble && (bus.E_icode != NOP)) begin
        r_perf_ops <= r_perf_ops + PERF_W'(1);
      end
      if (!bus.M_stall && bus.M_bubble) begin
        r_perf_bubbles <= r_perf_bubbles + PERF_W'(1);
      end
    end
  end

  assign bus.perf_ops     = r_perf_ops;
  assign bus.perf_bubbles = r_perf_bubbles;
`endif

  assign bus.e_valE  = w_val_e;
  assign bus.e_dstE  = w_dst_e;
  assign bus.e_cnd   = w_cnd;
  assign bus.M_stat  = r_m_stat;
  assign bus.M_icode = r_m_icode;
  assign bus.M_cnd   = r_m_cnd;
  assign bus.M_valE  = r_m_val_e;
  assign bus.M_valA  = r_m_val_a;
  assign bus.M_dstE  = r_m_dst_e;
  assign bus.M_dstM  = r_m_dst_m;
  assign bus.cc_zf   = r_cc.zf;
  assign bus.cc_sf   = r_cc.sf;
  assign bus.cc_of   = r_cc.of;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module      : tb_execute_stage
// Description : Scoreboard bench for execute_stage. A driver applies directed
//               vectors and queues hand-computed expectations; a monitor
//               checks forwarding outputs mid-cycle and M/CC after the edge.
//               Perf counters checked when EXEC_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if #(.W(64), .PERF_W(32)) bus ();

  execute_stage #(.W(64), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        mexc;
    logic        wexc;
    logic        stall;
    logic        bubble;
  } stim_t;

  typedef struct packed {
    logic [15:0] id;
    logic        chk_e;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_cnd;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE;
    logic [63:0] m_valA;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        zf;
    logic        sf;
    logic        of;
    logic        chk_perf;
    logic [31:0] ops;
    logic [31:0] bub;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_id   = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  function automatic stim_t st(input logic [3:0] icode, input logic [3:0] ifun,
                               input logic [63:0] va, input logic [63:0] vb,
                               input logic [3:0] de, input logic [3:0] dm);
    stim_t s;
    s = '0;
    s.stat = STAT_AOK; s.icode = icode; s.ifun = ifun;
    s.valA = va; s.valB = vb; s.dstE = de; s.dstM = dm;
    return s;
  endfunction

  // Expected after a normal load into M
  function automatic exp_t ex_load(input stim_t s, input logic [63:0] ve, input logic [3:0] de,
                                   input logic cnd, input logic zf, input logic sf, input logic of);
    exp_t x;
    x = '0;
    x.chk_e = 1'b1; x.e_valE = ve; x.e_dstE = de; x.e_cnd = cnd;
    x.m_stat = s.stat; x.m_icode = s.icode; x.m_cnd = cnd; x.m_valE = ve;
    x.m_valA = s.valA; x.m_dstE = de; x.m_dstM = s.dstM;
    x.zf = zf; x.sf = sf; x.of = of;
    return x;
  endfunction

  // Expected when M holds the previous contents
  function automatic exp_t ex_keep(input exp_t prev, input logic [63:0] ve, input logic [3:0] de, input logic cnd);
    exp_t x;
    x = prev;
    x.chk_e = 1'b1; x.e_valE = ve; x.e_dstE = de; x.e_cnd = cnd; x.chk_perf = 1'b0;
    return x;
  endfunction

  // Expected after a bubble (NOP) is loaded into M
  function automatic exp_t ex_nop(input logic [63:0] ve, input logic [3:0] de, input logic cnd,
                                  input logic zf, input logic sf, input logic of);
    exp_t x;
    x = '0;
    x.chk_e = 1'b1; x.e_valE = ve; x.e_dstE = de; x.e_cnd = cnd;
    x.m_stat = STAT_AOK; x.m_icode = NOP; x.m_dstE = RNONE; x.m_dstM = RNONE;
    x.zf = zf; x.sf = sf; x.of = of;
    return x;
  endfunction

  function automatic exp_t ex_rst();
    exp_t x;
    x = ex_nop(64'd0, RNONE, 1'b0, 1'b1, 1'b0, 1'b0);
    x.chk_e = 1'b0; x.chk_perf = 1'b1;
    return x;
  endfunction

  task automatic step(input stim_t s, input exp_t x);
    @(posedge clk);
    #2;
    rst          = s.rst;
    bus.E_stat   = s.stat;
    bus.E_icode  = s.icode;
    bus.E_ifun   = s.ifun;
    bus.E_valC   = s.valC;
    bus.E_valA   = s.valA;
    bus.E_valB   = s.valB;
    bus.E_dstE   = s.dstE;
    bus.E_dstM   = s.dstM;
    bus.m_exc    = s.mexc;
    bus.W_exc    = s.wexc;
    bus.M_stall  = s.stall;
    bus.M_bubble = s.bubble;
    row_id++;
    x.id = 16'(row_id);
    q.push_back(x);
  endtask

  // Monitor: forwarding outputs mid-cycle, registered state after the edge
  initial begin
    exp_t t;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        t = q.pop_front();
        if (t.chk_e) begin
          chk("e_valE", int'(t.id), bus.e_valE, t.e_valE);
          chk("e_dstE", int'(t.id), 64'(bus.e_dstE), 64'(t.e_dstE));
          chk("e_cnd",  int'(t.id), 64'(bus.e_cnd), 64'(t.e_cnd));
        end
        @(posedge clk);
        #1;
        chk("M_stat",  int'(t.id), 64'(bus.M_stat), 64'(t.m_stat));
        chk("M_icode", int'(t.id), 64'(bus.M_icode), 64'(t.m_icode));
        chk("M_cnd",   int'(t.id), 64'(bus.M_cnd), 64'(t.m_cnd));
        chk("M_valE",  int'(t.id), bus.M_valE, t.m_valE);
        chk("M_valA",  int'(t.id), bus.M_valA, t.m_valA);
        chk("M_dstE",  int'(t.id), 64'(bus.M_dstE), 64'(t.m_dstE));
        chk("M_dstM",  int'(t.id), 64'(bus.M_dstM), 64'(t.m_dstM));
        chk("cc_flags", int'(t.id), 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'({t.zf, t.sf, t.of}));
`ifdef EXEC_PERF_EN
        if (t.chk_perf) begin
          chk("perf_ops",     int'(t.id), 64'(bus.perf_ops), 64'(t.ops));
          chk("perf_bubbles", int'(t.id), 64'(bus.perf_bubbles), 64'(t.bub));
        end
`endif
      end
    end
  end

  // Directed stimulus
  initial begin
    stim_t s;
    exp_t  x;
    exp_t  x_hold;
    bus.E_stat = STAT_AOK; bus.E_icode = NOP; bus.E_ifun = 4'h0;
    bus.E_valC = '0; bus.E_valA = '0; bus.E_valB = '0;
    bus.E_dstE = RNONE; bus.E_dstM = RNONE;
    bus.m_exc = 1'b0; bus.W_exc = 1'b0; bus.M_stall = 1'b0; bus.M_bubble = 1'b0;

    // Reset for two cycles
    s = st(NOP, 4'h0, 64'd0, 64'd0, RNONE, RNONE); s.rst = 1'b1;
    step(s, ex_rst());
    step(s, ex_rst());

    // OPQ sub 1-1 = 0 -> ZF
    s = st(OPQ, 4'h1, 64'd1, 64'd1, 4'h2, RNONE);
    step(s, ex_load(s, 64'd0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0));
    // OPQ add overflow
    s = st(OPQ, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, RNONE);
    step(s, ex_load(s, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1));
    // OPQ sub 0-1 -> SF=1, OF=0
    s = st(OPQ, 4'h1, 64'd1, 64'd0, 4'h4, RNONE);
    step(s, ex_load(s, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0));
    // CMOVL taken, CMOVGE squashed
    s = st(RRMOVQ, 4'h2, 64'h55, 64'h999, 4'h3, RNONE);
    step(s, ex_load(s, 64'h55, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0));
    s = st(RRMOVQ, 4'h5, 64'h66, 64'h999, 4'h3, RNONE);
    step(s, ex_load(s, 64'h66, RNONE, 1'b0, 1'b0, 1'b1, 1'b0));
    // JE not taken (ZF=0), JLE taken, unknown ifun false
    s = st(JXX, 4'h3, 64'h0, 64'h0, RNONE, RNONE); s.valC = 64'h400;
    step(s, ex_load(s, 64'd0, RNONE, 1'b0, 1'b0, 1'b1, 1'b0));
    s = st(JXX, 4'h1, 64'h0, 64'h0, RNONE, RNONE);
    step(s, ex_load(s, 64'd0, RNONE, 1'b1, 1'b0, 1'b1, 1'b0));
    s = st(JXX, 4'h7, 64'h0, 64'h0, RNONE, RNONE);
    step(s, ex_load(s, 64'd0, RNONE, 1'b0, 1'b0, 1'b1, 1'b0));
    // Stack pointer arithmetic, CC untouched
    s = st(PUSHQ, 4'h0, 64'h77, 64'h100, 4'h4, RNONE);
    step(s, ex_load(s, 64'hF8, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0));
    s = st(POPQ, 4'h0, 64'h100, 64'h100, 4'h4, 4'h5);
    step(s, ex_load(s, 64'h108, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0));
    // IRMOVQ ignores valB
    s = st(IRMOVQ, 4'h0, 64'h0, 64'h999, 4'h6, RNONE); s.valC = 64'h1234;
    step(s, ex_load(s, 64'h1234, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0));
    // OPQ xor with m_exc: passes to M, CC unchanged
    s = st(OPQ, 4'h3, 64'h5, 64'h5, 4'h6, RNONE); s.mexc = 1'b1;
    x_hold = ex_load(s, 64'd0, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    step(s, x_hold);
    // Stall holds M and CC; stall+bubble still holds
    s = st(OPQ, 4'h2, 64'hF0, 64'h0F, 4'h7, RNONE); s.stall = 1'b1;
    step(s, ex_keep(x_hold, 64'd0, 4'h7, 1'b1));
    s.bubble = 1'b1;
    step(s, ex_keep(x_hold, 64'd0, 4'h7, 1'b1));
    // Bubble loads NOP, CC unchanged
    s = st(OPQ, 4'h0, 64'd1, 64'd1, 4'h7, RNONE); s.bubble = 1'b1;
    step(s, ex_nop(64'd2, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0));
    // Non-AOK stat or W_exc blocks CC update
    s = st(OPQ, 4'h1, 64'd2, 64'd2, 4'h8, RNONE); s.stat = STAT_ADR;
    step(s, ex_load(s, 64'd0, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0));
    s = st(OPQ, 4'h1, 64'd3, 64'd3, 4'hA, RNONE); s.wexc = 1'b1;
    step(s, ex_load(s, 64'd0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0));
    // OPQ and: OF cleared
    s = st(OPQ, 4'h2, 64'hFF00, 64'h0FF0, 4'h9, RNONE);
    step(s, ex_load(s, 64'h0F00, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0));
    // Reset mid-stream beats stall and bubble
    s = st(OPQ, 4'h0, 64'd1, 64'd2, 4'h9, RNONE); s.rst = 1'b1; s.stall = 1'b1; s.bubble = 1'b1;
    step(s, ex_rst());
    // JE after reset: ZF=1 -> taken
    s = st(JXX, 4'h3, 64'h0, 64'h0, RNONE, RNONE);
    step(s, ex_load(s, 64'd0, RNONE, 1'b1, 1'b1, 1'b0, 1'b0));

    // Perf section: reset, 5 OPQs, 2 bubbles, reset
    s = st(NOP, 4'h0, 64'd0, 64'd0, RNONE, RNONE); s.rst = 1'b1;
    step(s, ex_rst());
    for (int i = 1; i <= 5; i++) begin
      s = st(OPQ, 4'h0, 64'(i), 64'd10, 4'h0, RNONE);
      x = ex_load(s, 64'(10 + i), 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      x.chk_perf = 1'b1; x.ops = 32'(i); x.bub = 32'd0;
      step(s, x);
    end
    for (int i = 1; i <= 2; i++) begin
      s = st(NOP, 4'h0, 64'd0, 64'd0, RNONE, RNONE); s.bubble = 1'b1;
      x = ex_nop(64'd0, RNONE, 1'b1, 1'b0, 1'b0, 1'b0);
      x.chk_perf = 1'b1; x.ops = 32'd5; x.bub = 32'(i);
      step(s, x);
    end
    s = st(NOP, 4'h0, 64'd0, 64'd0, RNONE, RNONE); s.rst = 1'b1;
    step(s, ex_rst());

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before bound");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
